// File: rtl/mapa_pkg.sv
// Shared definitions for the map RAM arbiter: cell codes, default board geometry,
// FSM state and requester encodings.
package mapa_pkg;

    typedef enum logic [1:0] {
        VAZIO     = 2'b00,
        COBRA     = 2'b01,
        FRUTA     = 2'b10,
        OBSTACULO = 2'b11
    } cell_t;

    localparam int MAPA_WIDTH_DEF  = 40;
    localparam int MAPA_HEIGHT_DEF = 30;
    localparam int ADDR_W_DEF      = 11;
    localparam int COORD_W         = 10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_VGA  = 2'b01,
        SRC_UPD  = 2'b10,
        SRC_SPN  = 2'b11
    } src_t;

endpackage

// File: rtl/mapa_addr_calc.sv
// Combinational cell coordinate to linear RAM address conversion with an on-map flag.
module mapa_addr_calc
    import mapa_pkg::*;
#(
    parameter int MAPA_WIDTH  = MAPA_WIDTH_DEF,
    parameter int MAPA_HEIGHT = MAPA_HEIGHT_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_in_range
);

    localparam logic [ADDR_W-1:0]  W_ROW = ADDR_W'(MAPA_WIDTH);
    localparam logic [COORD_W-1:0] W_LIM = COORD_W'(MAPA_WIDTH);
    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(MAPA_HEIGHT);

    // Arithmetic is done directly at address width; wrap-around equals truncating the full product.
    always_comb begin
        o_addr     = (ADDR_W'(i_y) * W_ROW) + ADDR_W'(i_x);
        o_in_range = (i_x < W_LIM) && (i_y < H_LIM);
    end

endmodule

// File: rtl/mapa_arbiter.sv
// Map RAM owner: arbitrates VGA/update/spawner accesses and performs the board-clear sweep.
module mapa_arbiter
    import mapa_pkg::*;
#(
    parameter int MAPA_WIDTH  = MAPA_WIDTH_DEF,
    parameter int MAPA_HEIGHT = MAPA_HEIGHT_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vga_req,
    input  logic [COORD_W-1:0] vga_x,
    input  logic [COORD_W-1:0] vga_y,
    output logic               vga_ack,
    output logic               vga_rvalid,
    output logic [1:0]         vga_rdata,
    input  logic               upd_req,
    input  logic               upd_we,
    input  logic [COORD_W-1:0] upd_x,
    input  logic [COORD_W-1:0] upd_y,
    input  logic [1:0]         upd_wdata,
    output logic               upd_ack,
    output logic               upd_rvalid,
    output logic [1:0]         upd_rdata,
    input  logic               spn_req,
    input  logic               spn_we,
    input  logic [COORD_W-1:0] spn_x,
    input  logic [COORD_W-1:0] spn_y,
    input  logic [1:0]         spn_wdata,
    output logic               spn_ack,
    output logic               spn_rvalid,
    output logic [1:0]         spn_rdata,
    input  logic               clear_start,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [1:0]         ram_wdata,
    input  logic [1:0]         ram_rdata
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(MAPA_WIDTH * MAPA_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

    arb_state_t          r_state;
    logic                r_fav_spn;
    logic [ADDR_W-1:0]   r_sweep;
    logic                r_vga_ack;
    logic                r_upd_ack;
    logic                r_spn_ack;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_we;
    logic [1:0]          r_ram_wdata;
    logic                r_clear_busy;
    logic                r_clear_done;
    logic [2:0]          r_rd_pend;
    logic                r_rd_pend_oor;
    logic [2:0]          r_rvalid;
    logic                r_rvalid_oor;

    logic                w_elig_vga;
    logic                w_elig_upd;
    logic                w_elig_spn;
    src_t                w_gnt;
    logic [COORD_W-1:0]  w_sel_x;
    logic [COORD_W-1:0]  w_sel_y;
    logic                w_sel_we;
    logic [1:0]          w_sel_wdata;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_in_range;
    logic [1:0]          w_rd_cell;

    // Grant selection; a requester whose ack is high this cycle cannot win again.
    always_comb begin
        w_elig_vga = vga_req & ~r_vga_ack;
        w_elig_upd = upd_req & ~r_upd_ack;
        w_elig_spn = spn_req & ~r_spn_ack;
        w_gnt      = SRC_NONE;
        if ((r_state == ST_IDLE) && !clear_start) begin
            if (w_elig_vga) begin
                w_gnt = SRC_VGA;
            end else if (w_elig_upd && (!w_elig_spn || !r_fav_spn)) begin
                w_gnt = SRC_UPD;
            end else if (w_elig_spn) begin
                w_gnt = SRC_SPN;
            end else begin
                w_gnt = SRC_NONE;
            end
        end else begin
            w_gnt = SRC_NONE;
        end
    end

    // Request mux feeding the single address calculator.
    always_comb begin
        w_sel_x     = '0;
        w_sel_y     = '0;
        w_sel_we    = 1'b0;
        w_sel_wdata = VAZIO;
        case (w_gnt)
            SRC_VGA: begin
                w_sel_x = vga_x;
                w_sel_y = vga_y;
            end
            SRC_UPD: begin
                w_sel_x     = upd_x;
                w_sel_y     = upd_y;
                w_sel_we    = upd_we;
                w_sel_wdata = upd_wdata;
            end
            SRC_SPN: begin
                w_sel_x     = spn_x;
                w_sel_y     = spn_y;
                w_sel_we    = spn_we;
                w_sel_wdata = spn_wdata;
            end
            default: begin
                w_sel_x = '0;
            end
        endcase
    end

    mapa_addr_calc #(
        .MAPA_WIDTH  (MAPA_WIDTH),
        .MAPA_HEIGHT (MAPA_HEIGHT),
        .ADDR_W      (ADDR_W)
    ) u_addr_calc (
        .i_x        (w_sel_x),
        .i_y        (w_sel_y),
        .o_addr     (w_addr),
        .o_in_range (w_in_range)
    );

    // Arbiter FSM, RAM port registers, sweep counter and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_fav_spn     <= 1'b0;
            r_sweep       <= '0;
            r_vga_ack     <= 1'b0;
            r_upd_ack     <= 1'b0;
            r_spn_ack     <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_we      <= 1'b0;
            r_ram_wdata   <= VAZIO;
            r_clear_busy  <= 1'b0;
            r_clear_done  <= 1'b0;
            r_rd_pend     <= 3'b000;
            r_rd_pend_oor <= 1'b0;
            r_rvalid      <= 3'b000;
            r_rvalid_oor  <= 1'b0;
        end else begin
            r_vga_ack     <= 1'b0;
            r_upd_ack     <= 1'b0;
            r_spn_ack     <= 1'b0;
            r_ram_we      <= 1'b0;
            r_clear_done  <= 1'b0;
            r_rd_pend     <= 3'b000;
            r_rd_pend_oor <= 1'b0;
            r_rvalid      <= r_rd_pend;
            r_rvalid_oor  <= r_rd_pend_oor;
            case (r_state)
                ST_IDLE: begin
                    if (clear_start) begin
                        r_state      <= ST_CLEAR;
                        r_sweep      <= '0;
                        r_ram_addr   <= '0;
                        r_ram_we     <= 1'b1;
                        r_ram_wdata  <= VAZIO;
                        r_clear_busy <= 1'b1;
                    end else if (w_gnt != SRC_NONE) begin
                        r_vga_ack     <= (w_gnt == SRC_VGA);
                        r_upd_ack     <= (w_gnt == SRC_UPD);
                        r_spn_ack     <= (w_gnt == SRC_SPN);
                        r_ram_we      <= w_sel_we & w_in_range;
                        r_ram_wdata   <= w_sel_wdata;
                        r_rd_pend     <= {w_gnt == SRC_SPN, w_gnt == SRC_UPD, w_gnt == SRC_VGA}
                                         & {3{~w_sel_we}};
                        r_rd_pend_oor <= ~w_in_range;
                        // Off-map accesses leave the RAM address untouched.
                        if (w_in_range) begin
                            r_ram_addr <= w_addr;
                        end else begin
                            r_ram_addr <= r_ram_addr;
                        end
                        if (w_gnt != SRC_VGA) begin
                            r_fav_spn <= ~r_fav_spn;
                        end else begin
                            r_fav_spn <= r_fav_spn;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (r_sweep == LAST_CELL) begin
                        r_state      <= ST_IDLE;
                        r_clear_busy <= 1'b0;
                        r_clear_done <= 1'b1;
                    end else begin
                        r_sweep     <= r_sweep + ONE_A;
                        r_ram_addr  <= r_sweep + ONE_A;
                        r_ram_we    <= 1'b1;
                        r_ram_wdata <= VAZIO;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data is the RAM's own output register steered by registered selects,
    // which is what lets rvalid land two cycles after the grant edge.
    always_comb begin
        if (r_rvalid_oor) begin
            w_rd_cell = OBSTACULO;
        end else begin
            w_rd_cell = ram_rdata;
        end
    end

    assign vga_rdata  = r_rvalid[0] ? w_rd_cell : VAZIO;
    assign upd_rdata  = r_rvalid[1] ? w_rd_cell : VAZIO;
    assign spn_rdata  = r_rvalid[2] ? w_rd_cell : VAZIO;
    assign vga_rvalid = r_rvalid[0];
    assign upd_rvalid = r_rvalid[1];
    assign spn_rvalid = r_rvalid[2];
    assign vga_ack    = r_vga_ack;
    assign upd_ack    = r_upd_ack;
    assign spn_ack    = r_spn_ack;
    assign clear_busy = r_clear_busy;
    assign clear_done = r_clear_done;
    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: doc/mapa_arbiter.md
Name: mapa_arbiter

Overview:
- Owns the single-port map RAM: 2-bit cells, MAPA_WIDTH x MAPA_HEIGHT, 1-cycle synchronous read.
- Shares the RAM between three requesters: VGA renderer (read-only), game update FSM (read/write) and fruit/obstacle spawner (read/write).
- Contains the board-clear sweep, so requesters never write the RAM directly.

Parameters:
MAPA_WIDTH, 40, cells per row
MAPA_HEIGHT, 30, rows
ADDR_W, 11, RAM address width; must satisfy 2^ADDR_W >= MAPA_WIDTH*MAPA_HEIGHT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vga_req  in  1  VGA read request, held until vga_ack
vga_x, vga_y  in  10 each  VGA cell coordinate
vga_ack  out  1  1-cycle grant pulse
vga_rvalid  out  1  vga_rdata valid, 1 cycle
vga_rdata  out  2  cell read
upd_req, upd_we  in  1 each  update request; 1 = write
upd_x, upd_y  in  10 each  update coordinate
upd_wdata  in  2  update write data
upd_ack, upd_rvalid  out  1 each  grant pulse / read valid
upd_rdata  out  2  update read data
spn_req, spn_we, spn_x, spn_y, spn_wdata  in  1,1,10,10,2  spawner request, same meaning as upd_*
spn_ack, spn_rvalid, spn_rdata  out  1,1,2  spawner grant / read valid / read data
clear_start  in  1  pulse: sweep whole map to 2'b00
clear_busy  out  1  sweep in progress
clear_done  out  1  1-cycle pulse at sweep end
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  2  RAM write data
ram_rdata  in  2  RAM read data, valid the cycle after the address is driven

Behaviour:
- All outputs are registered.
- Reset: every output 0; FSM to IDLE; round-robin pointer favours upd; sweep counter 0; any pending rvalid cancelled.
- FSM states: IDLE and CLEAR.
  - IDLE, clear_start=1 at an edge: enter CLEAR. No grant at that edge; requests sampled at that edge are stalled, not dropped.
  - CLEAR: one write per cycle, ram_we=1, ram_wdata=00, addr 0..W*H-1; clear_busy=1 for all W*H cycles.
  - CLEAR exit: clear_done pulses the cycle after the last write, together with return to IDLE. clear_start while in CLEAR is ignored. No ack is issued during CLEAR.
- Grant (IDLE, each edge), at most one:
  - Priority: vga, then upd/spn by round-robin.
  - Pointer toggles only when upd or spn is granted.
  - A requester whose ack is currently high is ineligible, so one request gives exactly one grant. Maximum per-requester rate is 1 access every 2 cycles.
- Granted access (edge N):
  - Cycle N+1: ack=1, ram_addr = y*MAPA_WIDTH + x (truncated to ADDR_W), ram_we = we, ram_wdata = wdata.
  - Reads only: rvalid=1 in cycle N+2, with rdata = ram_rdata.
  - Writes produce ack only, never rvalid.
  - VGA is always a read.
- Out of range (x >= MAPA_WIDTH or y >= MAPA_HEIGHT): access is still acked, but ram_we=0 and ram_addr holds its previous value.
  - Write is dropped.
  - Read returns rdata=11 (obstacle; off-map reads as wall) with normal rvalid timing.
- Cycles with no grant: ram_we=0, ram_addr holds.
- Request inputs are sampled only at the grant edge; changes after ack have no effect.
- Reset mid-sweep or mid-read: sweep aborted, no clear_done, rvalid suppressed.

Decomposition:
- Shared package mapa_pkg:
  - cell codes VAZIO=00, COBRA=01, FRUTA=10, OBSTACULO=11
  - default MAPA_WIDTH/MAPA_HEIGHT
  - address-width constant
- Sub-module mapa_addr_calc: combinational; (x, y) -> addr plus in_range flag. Instantiated once, after the request mux.

Test Plan:
- Reset, then idle with no requests -> all outputs 0, ram_we never 1.
- clear_start pulse; upd_req held throughout -> 1200 cycles of ram_we=1, wdata=00, addr 0..1199; clear_done pulses at cycle 1201; upd_ack arrives only after clear_done.
- Update write x=10, y=10, data 01 -> next cycle ram_addr=410, ram_we=1, ram_wdata=01, upd_ack=1; upd_rvalid stays 0.
- vga, upd, spn read requests held continuously -> grant order vga, upd, vga, spn, vga, upd...; each rvalid arrives 2 cycles after its sampling edge with the RAM data.
- spn read x=40, y=0 -> spn_ack, ram_we=0, spn_rvalid next cycle with rdata=11. upd write y=30 -> upd_ack, no RAM write.
- reset asserted at sweep cell 500 -> clear_busy=0 the next cycle, clear_done never pulses, all outputs 0.
